register_bus_master: RTL and testbench
======================================

// Module: register_bus_master
// PURPOSE
// - Initiator for the Uniboard peripheral register bus (databus/register_addr/rw/select/reg_size).
// - Accepts one register request at a time from the command layer (valid/ready), runs one bus
//   transaction with correct setup/strobe/turnaround timing, returns read data, size and error.
// - Sits between the host command parser and all axis/peripheral responders sharing the bus.
// PARAMETERS
// - STROBE_CYCLES  3  cycles select is held high (min 3: responder edge-detect + read latch + sample)
// - GAP_CYCLES     1  idle cycles after select falls before next setup (bus turnaround)
// PORTS
// - clk_12MHz      in   1   system clock, sole clock domain
// - reset          in   1   synchronous, active-high reset
// - req_valid      in   1   request present
// - req_ready      out  1   master idle; request accepted when req_valid & req_ready
// - req_rw         in   1   0 = write, 1 = read
// - req_addr       in   8   register address
// - req_wdata      in   32  write data (ignored for reads)
// - rsp_valid      out  1   one-cycle pulse: transaction complete
// - rsp_rdata      out  32  read data masked to rsp_size bytes; 0 for writes
// - rsp_size       out  3   reg_size sampled from responder (bytes); 0 for writes
// - rsp_err        out  1   read returned size 0 or size > 4 (no/invalid responder)
// - databus        inout 32 shared data bus; driven only during write SETUP/STROBE
// - reg_size       in   3   responder-driven register size (tri on bus)
// - register_addr  out  8   bus address
// - rw             out  1   bus direction, 0 = write, 1 = read
// - select         out  1   bus strobe; rising edge = transaction start
// BEHAVIOUR
// - Reset: select=0, rw=1, register_addr=0, databus released ('z), req_ready=0 during reset then 1,
//   rsp_valid=0, rsp_rdata=0, rsp_size=0, rsp_err=0, state=IDLE. Reset mid-transaction aborts
//   immediately: select drops and databus releases on the next edge, no rsp_valid.
// - All bus outputs registered; databus enable registered.
// - FSM: IDLE -> SETUP -> STROBE -> GAP -> IDLE.
//   IDLE: req_ready=1. On accept latch rw/addr/wdata, drive register_addr, rw; for write enable
//     databus drive; -> SETUP. req_ready=0 outside IDLE.
//   SETUP (1 cycle): addr/rw/data stable with select=0 (guarantees setup before responder edge).
//   STROBE: select=1 for exactly STROBE_CYCLES cycles (counter). On last STROBE cycle, if read,
//     sample databus and reg_size into rsp regs. Then select=0, databus released, rw returns to 1.
//   GAP: GAP_CYCLES cycles idle; rsp_valid pulses on first GAP cycle; -> IDLE.
// - Latency: accept at edge N -> select rises N+2 -> rsp_valid at N+2+STROBE_CYCLES;
//   next accept no earlier than rsp_valid + GAP_CYCLES.
// - Read masking: size 1 -> [7:0], 2 -> [15:0], 3 -> [23:0], 4 -> [31:0]; others -> rdata=0, rsp_err=1.
// - Write: rsp_err=0, rsp_size=0 (responders do not acknowledge writes).
// - rw held 1 whenever select=0 so no responder ever sees a write edge while idle.
// - Master never drives databus while rw=1; one released cycle separates a write from any read.
// - req_valid while busy is ignored (held by producer); req fields sampled only on accept.
// - Back-to-back requests to the same address are legal; each gives a fresh select rising edge.
// STRUCTURE
// - Package uniboard_bus_pkg: bus_state_t enum {IDLE,SETUP,STROBE,GAP}; RW_WRITE/RW_READ constants;
//   BUS_DATA_W=32, BUS_ADDR_W=8, BUS_SIZE_W=3; function size_mask(size)->32-bit mask.
// - Single module, no sub-module; tristate driven by one registered output-enable.
// TESTING
// - Write 0x2A to addr 0x00 on model responder -> databus=0x0000002A at select rise, rw=0,
//   responder register updates once, rsp_valid with rsp_size=0, rsp_err=0.
// - Read addr 0x02, responder holds 0x00002EE0 size 4 -> rsp_rdata=0x00002EE0, rsp_size=4.
// - Read addr 0x01 responder returns 0xFFFFFF05 size 1 -> rsp_rdata=0x00000005, rsp_size=1.
// - Read unmapped addr 0x7F (size 0) -> rsp_err=1, rsp_rdata=0; no hang, returns to IDLE.
// - Write then read back-to-back (req_valid held) -> select low >= GAP_CYCLES between,
//   databus undriven by master during read; no X/contention on bus.
// - Assert reset in middle of STROBE -> select=0 and databus 'z next cycle, no rsp_valid, req_ready=1 after.

Source files
------------

// File: rtl/uniboard_bus_pkg.sv
// -----------------------------------------------------------------------------
// uniboard_bus_pkg
// Shared types and constants for the Uniboard peripheral register bus.
//   bus_state_t : initiator transaction phases
//   RW_WRITE / RW_READ : values of the rw bus line
//   BUS_DATA_W / BUS_ADDR_W / BUS_SIZE_W : bus field widths
//   size_mask() : byte-lane mask for a responder-reported register size
// -----------------------------------------------------------------------------
package uniboard_bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 8;
  localparam int BUS_SIZE_W = 3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } bus_state_t;

  // Mask of valid byte lanes for a register of 'size' bytes. Any size outside
  // 1..4 means no (or a broken) responder answered, so no lane is valid; an
  // all-zero mask doubles as the error indication.
  function automatic logic [BUS_DATA_W-1:0] size_mask(input logic [BUS_SIZE_W-1:0] size);
    logic [BUS_DATA_W-1:0] mask;
    case (size)
      3'd1:    mask = 32'h0000_00FF;
      3'd2:    mask = 32'h0000_FFFF;
      3'd3:    mask = 32'h00FF_FFFF;
      3'd4:    mask = 32'hFFFF_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/register_bus_master.sv
// -----------------------------------------------------------------------------
// register_bus_master
// Initiator for the Uniboard peripheral register bus. Takes one request at a
// time from the command layer, runs a single bus transaction
// (SETUP -> STROBE -> GAP) and reports read data, size and error.
//
// Parameters
//   STROBE_CYCLES : cycles select is held high (>= 3 so responders can
//                   edge-detect, latch read data and present it)
//   GAP_CYCLES    : idle cycles after select falls before the next setup (>= 1)
//
// Ports
//   clk_12MHz     in    system clock
//   reset         in    synchronous active-high reset
//   req_valid     in    request present
//   req_ready     out   master idle; request taken on req_valid & req_ready
//   req_rw        in    0 = write, 1 = read
//   req_addr      in    register address
//   req_wdata     in    write data
//   rsp_valid     out   one-cycle pulse when the transaction completes
//   rsp_rdata     out   read data masked to rsp_size bytes (0 for writes)
//   rsp_size      out   reg_size sampled from the responder (0 for writes)
//   rsp_err       out   read answered with size 0 or size > 4
//   databus       inout shared data bus, driven only during write SETUP/STROBE
//   reg_size      in    responder-driven register size
//   register_addr out   bus address
//   rw            out   bus direction, 0 = write, 1 = read
//   select        out   bus strobe; rising edge starts a responder access
// -----------------------------------------------------------------------------
module register_bus_master
  import uniboard_bus_pkg::*;
#(
  parameter int STROBE_CYCLES = 3,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                  clk_12MHz,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [BUS_DATA_W-1:0] rsp_rdata,
  output logic [BUS_SIZE_W-1:0] rsp_size,
  output logic                  rsp_err,
  inout  wire  [BUS_DATA_W-1:0] databus,
  input  logic [BUS_SIZE_W-1:0] reg_size,
  output logic [BUS_ADDR_W-1:0] register_addr,
  output logic                  rw,
  output logic                  select
);

  // Phase counter is shared by STROBE and GAP; 8 bits covers any sane setting.
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  bus_state_t            r_state;
  logic [7:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_select;
  logic                  r_rw;
  logic [BUS_ADDR_W-1:0] r_addr;
  logic [BUS_DATA_W-1:0] r_wdata;
  logic                  r_oe;
  logic                  r_rsp_valid;
  logic [BUS_DATA_W-1:0] r_rsp_rdata;
  logic [BUS_SIZE_W-1:0] r_rsp_size;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic [BUS_DATA_W-1:0] w_mask;

  // r_req_ready is only ever set while in IDLE, so it alone qualifies accept.
  assign w_accept = req_valid && r_req_ready;
  assign w_mask   = size_mask(reg_size);

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_select    <= 1'b0;
      r_rw        <= RW_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_size  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also raises req_ready on the first cycle out of reset.
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_rw        <= req_rw;
            r_wdata     <= req_wdata;
            // Only writes drive the bus, and the enable rises together with
            // rw=0 so the master never drives while rw=1.
            r_oe        <= (req_rw == RW_WRITE);
            r_state     <= SETUP;
          end
        end

        SETUP: begin
          // Address, direction and write data have now been stable for a
          // full cycle, so the responder sees them settled at the select edge.
          r_select <= 1'b1;
          r_cnt    <= '0;
          r_state  <= STROBE;
        end

        STROBE: begin
          if (r_cnt == STROBE_LAST) begin
            r_select    <= 1'b0;
            r_oe        <= 1'b0;
            r_rw        <= RW_READ;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= GAP;
            if (r_rw == RW_READ) begin
              r_rsp_size  <= reg_size;
              r_rsp_rdata <= databus & w_mask;
              r_rsp_err   <= (w_mask == '0);
            end else begin
              // Responders never acknowledge writes.
              r_rsp_size  <= '0;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_select    <= 1'b0;
          r_oe        <= 1'b0;
          r_rw        <= RW_READ;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Single registered enable controls the tristate driver.
  assign databus = r_oe ? r_wdata : {BUS_DATA_W{1'bz}};

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_size      = r_rsp_size;
  assign rsp_err       = r_rsp_err;
  assign register_addr = r_addr;
  assign rw            = r_rw;
  assign select        = r_select;

endmodule

// File: tb/tb_register_bus_master.sv
// -----------------------------------------------------------------------------
// tb_register_bus_master
// Bench for register_bus_master with a model responder on the bus. Requests
// are pushed into an expectation queue when accepted; a monitor compares
// every response and every select strobe against the head of that queue.
// Responder map: addresses 0x00..0x3F answer (size from a fixed table),
// 0x40..0xFF have no responder.
// -----------------------------------------------------------------------------
module tb_register_bus_master;

  localparam int STROBE_CYCLES = 3;
  localparam int GAP_CYCLES    = 1;

  logic        clk_12MHz = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_size;
  logic        rsp_err;
  wire  [31:0] databus;
  logic [2:0]  reg_size;
  logic [7:0]  register_addr;
  logic        rw;
  logic        select;

  always #5 clk_12MHz = ~clk_12MHz;

  register_bus_master #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk_12MHz    (clk_12MHz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_size     (rsp_size),
    .rsp_err      (rsp_err),
    .databus      (databus),
    .reg_size     (reg_size),
    .register_addr(register_addr),
    .rw           (rw),
    .select       (select)
  );

  // ---------------------------------------------------------------- responder
  function automatic logic [31:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    if (a == 1) return 32'hFFFF_FF05;
    if (a == 2) return 32'h0000_2EE0;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  function automatic bit mapped(input logic [7:0] a);
    return a < 8'h40;
  endfunction

  function automatic logic [2:0] size_of(input logic [7:0] a);
    if (a == 8'h00 || a == 8'h02) return 3'd4;
    if (a == 8'h01) return 3'd1;
    return a[2:0];
  endfunction

  logic [31:0] resp_mem [256];
  logic        resp_prev_sel;
  int          wr_edges = 0;

  always @(posedge clk_12MHz) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) resp_mem[i] <= init_val(i);
      resp_prev_sel <= 1'b0;
    end else begin
      resp_prev_sel <= select;
      if (select && !resp_prev_sel && rw == 1'b0 && mapped(register_addr)) begin
        resp_mem[register_addr] <= databus;
        wr_edges <= wr_edges + 1;
      end
    end
  end

  assign databus  = (select && rw && mapped(register_addr)) ? resp_mem[register_addr] : 32'hzzzz_zzzz;
  assign reg_size = (select && mapped(register_addr)) ? size_of(register_addr) : 3'd0;

  // ------------------------------------------------------- reference/scoreboard
  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  size;
    logic        err;
    int          acc_cyc;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_wr = 0;

  always @(posedge clk_12MHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  // Issue one request; hold keeps req_valid asserted after acceptance so the
  // next call presents its request back-to-back.
  task automatic issue(input bit is_rd, input logic [7:0] a, input logic [31:0] d, input bit hold);
    txn_t t;
    int   n;
    int   s;
    @(negedge clk_12MHz);
    req_valid = 1'b1;
    req_rw    = is_rd;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready) begin
      @(negedge clk_12MHz);
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 50 cycles");
        req_valid = 1'b0;
        return;
      end
    end
    t.rw      = is_rd;
    t.addr    = a;
    t.wdata   = d;
    t.acc_cyc = cyc;
    if (!is_rd) begin
      t.rdata = 32'h0; t.size = 3'd0; t.err = 1'b0;
      if (mapped(a)) begin
        ref_mem[a] = d;
        exp_wr++;
      end
    end else begin
      s = mapped(a) ? int'(size_of(a)) : 0;
      t.size = 3'(s);
      if (s >= 1 && s <= 4) begin
        t.rdata = 32'(longint'(ref_mem[a]) % (longint'(1) << (8 * s)));
        t.err   = 1'b0;
      end else begin
        t.rdata = 32'h0;
        t.err   = 1'b1;
      end
    end
    exp_q.push_back(t);
    $display("issue %s addr=%h wdata=%h exp_rdata=%h exp_size=%0d exp_err=%0d",
             is_rd ? "RD" : "WR", a, d, t.rdata, t.size, t.err);
    @(posedge clk_12MHz);
    if (!hold) begin
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_12MHz);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk_12MHz);
  endtask

  // ------------------------------------------------------------------ monitor
  initial begin : monitor
    txn_t t;
    bit   mon_prev;
    bit   seen_fall;
    int   hi_cnt;
    int   low_cnt;
    mon_prev  = 1'b0;
    seen_fall = 1'b0;
    hi_cnt    = 0;
    low_cnt   = 0;
    forever begin
      @(negedge clk_12MHz);
      if (reset) begin
        mon_prev  = 1'b0;
        seen_fall = 1'b0;
        hi_cnt    = 0;
        low_cnt   = 0;
      end else begin
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
          end else begin
            t = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, t.rdata);
            check("rsp_size", 32'(rsp_size), 32'(t.size));
            check("rsp_err", 32'(rsp_err), 32'(t.err));
            check("rsp_latency", 32'(cyc - t.acc_cyc), 32'(STROBE_CYCLES + 2));
            $display("rsp  addr=%h rdata=%h size=%0d err=%0d", t.addr, rsp_rdata, rsp_size, rsp_err);
          end
        end
        if (req_ready) begin
          check("idle_rw_high", 32'(rw), 32'h1);
          check("idle_select_low", 32'(select), 32'h0);
        end
        if (select) begin
          if (!mon_prev) begin
            if (exp_q.size() == 0) begin
              check("unexpected_select", 32'(select), 32'h0);
            end else begin
              t = exp_q[0];
              check("strobe_addr", 32'(register_addr), 32'(t.addr));
              check("strobe_rw", 32'(rw), 32'(t.rw));
              if (!t.rw) check("strobe_wdata", databus, t.wdata);
              check("select_latency", 32'(cyc - t.acc_cyc), 32'h2);
            end
            if (seen_fall) check("gap_ok", 32'(low_cnt >= GAP_CYCLES), 32'h1);
            hi_cnt = 0;
          end
          hi_cnt++;
        end else begin
          if (mon_prev) begin
            check("strobe_width", 32'(hi_cnt), 32'(STROBE_CYCLES));
            seen_fall = 1'b1;
            low_cnt   = 0;
          end
          low_cnt++;
        end
        mon_prev = select;
      end
    end
  end

  // ------------------------------------------------------------------- driver
  initial begin : driver
    logic [7:0]  a;
    logic [31:0] d;
    int          n;
    int          mism;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = 8'h0;
    req_wdata = 32'h0;
    ref_reset();
    repeat (3) @(posedge clk_12MHz);
    @(negedge clk_12MHz);
    check("reset_select", 32'(select), 32'h0);
    check("reset_rw", 32'(rw), 32'h1);
    check("reset_addr", 32'(register_addr), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_size", 32'(rsp_size), 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    reset = 1'b0;
    @(negedge clk_12MHz);
    check("ready_after_reset", 32'(req_ready), 32'h1);

    // Directed cases
    issue(1'b0, 8'h00, 32'h0000_002A, 1'b0);
    drain();
    check("responder_reg0", resp_mem[0], 32'h0000_002A);
    check("responder_wr_once", 32'(wr_edges), 32'h1);
    issue(1'b1, 8'h02, 32'h0, 1'b0);
    issue(1'b1, 8'h01, 32'h0, 1'b0);
    issue(1'b1, 8'h7F, 32'h0, 1'b0);
    drain();
    issue(1'b0, 8'h04, 32'h1357_9BDF, 1'b1);
    issue(1'b1, 8'h04, 32'h0, 1'b0);
    drain();

    // Reset in the middle of a write strobe
    issue(1'b0, 8'h10, 32'hDEAD_BEEF, 1'b0);
    n = 0;
    while (!select && n < 20) begin
      @(negedge clk_12MHz);
      n++;
    end
    check("abort_select_seen", 32'(select), 32'h1);
    @(negedge clk_12MHz);
    reset = 1'b1;
    @(negedge clk_12MHz);
    check("abort_select", 32'(select), 32'h0);
    check("abort_rw", 32'(rw), 32'h1);
    check("abort_bus_released", 32'(databus == 32'hDEAD_BEEF), 32'h0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h0);
    exp_q.delete();
    ref_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_12MHz);
    check("abort_ready_after", 32'(req_ready), 32'h1);
    repeat (6) @(negedge clk_12MHz);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(64, 255));
      d = $urandom;
      issue(1'($urandom_range(0, 1)), a, d, (i != 59) && ($urandom_range(0, 1) == 1));
    end
    drain();

    check("responder_write_count", 32'(wr_edges), 32'(exp_wr));
    mism = 0;
    for (int i = 0; i < 256; i++) if (resp_mem[i] !== ref_mem[i]) mism++;
    check("responder_contents", 32'(mism), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
